// File: rtl/gate_func_identifier.sv
// Probes an unknown 2-input logic unit with all four (a,b) vectors and decodes
// its select code from the captured truth table. Optional GFI_CHECK_EN adds exp_sel/pass.
module gate_func_identifier #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       probe_a,
  output logic       probe_b,
  input  logic       func_out,
  output logic       busy,
  output logic       done,
  output logic [2:0] sel_found,
  output logic       unknown,
  output logic [3:0] tt
`ifdef GFI_CHECK_EN
  ,
  input  logic [2:0] exp_sel,
  output logic       pass
`endif
);

  typedef enum logic [1:0] {IDLE, PROBE, DECODE} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(SETTLE);

  state_t     state;
  logic [1:0] idx;
  logic [3:0] hold;
  logic [2:0] cap;
  logic [3:0] tt_next;
  logic [2:0] dec_sel;
  logic       dec_unk;

  // The last sample goes straight into the decode so results land with done.
  assign tt_next = {func_out, cap};

  always_comb begin
    dec_sel = 3'b111;
    dec_unk = 1'b0;
    case (tt_next)
      4'b0011: dec_sel = 3'b000;
      4'b0001: dec_sel = 3'b001;
      4'b1000: dec_sel = 3'b010;
      4'b1110: dec_sel = 3'b011;
      4'b0110: dec_sel = 3'b100;
      4'b1001: dec_sel = 3'b101;
      4'b0111: dec_sel = 3'b110;
      default: dec_unk = 1'b1;
    endcase
  end

`ifdef GFI_CHECK_EN
  logic [2:0] exp_norm;
  assign exp_norm = (exp_sel == 3'b111) ? 3'b110 : exp_sel;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      hold      <= '0;
      cap       <= '0;
      probe_a   <= 1'b0;
      probe_b   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sel_found <= '0;
      unknown   <= 1'b0;
      tt        <= '0;
`ifdef GFI_CHECK_EN
      pass      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= PROBE;
            idx     <= '0;
            hold    <= '0;
            probe_a <= 1'b0;
            probe_b <= 1'b0;
            busy    <= 1'b1;
          end
        end
        PROBE: begin
          if (hold == HOLD_LAST) begin
            hold <= '0;
            if (idx == 2'd3) begin
              state     <= DECODE;
              done      <= 1'b1;
              tt        <= tt_next;
              sel_found <= dec_sel;
              unknown   <= dec_unk;
`ifdef GFI_CHECK_EN
              pass      <= (dec_sel == exp_norm) && !dec_unk;
`endif
              probe_a   <= 1'b0;
              probe_b   <= 1'b0;
            end else begin
              cap[idx]           <= func_out;
              idx                <= idx + 2'd1;
              {probe_a, probe_b} <= idx + 2'd1;
            end
          end else begin
            hold <= hold + 4'd1;
          end
        end
        DECODE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_func_identifier.sv
// Directed bench: three identifiers (SETTLE 0, 1, 3) each probe a behavioural
// model of the 2-input logic unit; expectations are hand-computed constants.
module tb_gate_func_identifier;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] mode = 4'd2;
  logic [2:0] exp_sel = 3'b000;

  logic       pa [3];
  logic       pb [3];
  logic       fo [3];
  logic       bsy [3];
  logic       dn [3];
  logic [2:0] sf [3];
  logic       unk [3];
  logic [3:0] ttv [3];
`ifdef GFI_CHECK_EN
  logic       pas [3];
`endif

  int cyc = 0;
  int k;
  int dcyc [3];
  int ndone;
  int nchk = 0;
  int npass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Logic unit model: modes 0..7 are the sel codes, anything else is constant 1.
  function automatic logic unit(input logic [3:0] m, input logic a, input logic b);
    case (m)
      4'd0: unit = ~a;
      4'd1: unit = ~(a | b);
      4'd2: unit = a & b;
      4'd3: unit = a | b;
      4'd4: unit = a ^ b;
      4'd5: unit = ~(a ^ b);
      4'd6, 4'd7: unit = ~(a & b);
      default: unit = 1'b1;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned S = (g == 0) ? 0 : (g == 1) ? 1 : 3;
    assign fo[g] = unit(mode, pa[g], pb[g]);
    gate_func_identifier #(.SETTLE(S)) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .probe_a(pa[g]), .probe_b(pb[g]), .func_out(fo[g]),
      .busy(bsy[g]), .done(dn[g]), .sel_found(sf[g]),
      .unknown(unk[g]), .tt(ttv[g])
`ifdef GFI_CHECK_EN
      , .exp_sel(exp_sel), .pass(pas[g])
`endif
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic scan();
    for (int i = 0; i < 3; i++)
      if (dn[i]) begin
        if (dcyc[i] < 0) dcyc[i] = cyc + 1 - k;
        if (i == 1) ndone++;
      end
  endtask

  // Pulse start for one cycle and watch all three instances for 25 cycles.
  task automatic run_all(input logic [3:0] m);
    mode = m;
    @(negedge clk);
    start = 1'b1;
    k = cyc + 1;
    ndone = 0;
    for (int i = 0; i < 3; i++) dcyc[i] = -1;
    @(negedge clk);
    start = 1'b0;
    scan();
    repeat (25) begin
      @(negedge clk);
      scan();
    end
  endtask

  logic [2:0] sweep_exp [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6};
  int lat_exp [3] = '{5, 9, 17};
  int d1, d2;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", bsy[1], 0);
    check("reset done", dn[1], 0);
    check("reset sel", sf[1], 0);
    check("reset unknown", unk[1], 0);
    check("reset tt", ttv[1], 0);
    check("reset probes", {pa[1], pb[1]}, 0);
`ifdef GFI_CHECK_EN
    check("reset pass", pas[1], 0);
`endif

    // Test 1: AND unit, probe sequence on the SETTLE=1 instance.
    mode = 4'd2;
    start = 1'b1;
    k = cyc + 1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("and probe %0d", j), {pa[1], pb[1]}, j / 2);
      check($sformatf("and busy %0d", j), bsy[1], 1);
      check($sformatf("and nodone %0d", j), dn[1], 0);
    end
    @(negedge clk);
    check("and done", dn[1], 1);
    check("and done cycle", cyc + 1 - k, 9);
    check("and tt", ttv[1], 4'b1000);
    check("and sel", sf[1], 3'b010);
    check("and unknown", unk[1], 0);
    @(negedge clk);
    check("and done pulse", dn[1], 0);
    check("and busy drop", bsy[1], 0);
    check("and sel hold", sf[1], 3'b010);
    repeat (10) @(negedge clk);

    // Test 2: sweep all select codes; latency per SETTLE.
    for (int s = 0; s < 8; s++) begin
      run_all(4'(s));
      check($sformatf("sweep sel %0d", s), sf[1], sweep_exp[s]);
      check($sformatf("sweep unknown %0d", s), unk[1], 0);
      check($sformatf("sweep sel3 %0d", s), sf[2], sweep_exp[s]);
    end
    for (int i = 0; i < 3; i++)
      check($sformatf("latency inst %0d", i), dcyc[i], lat_exp[i]);

    // Test 3: constant-1 unit.
    run_all(4'd8);
    check("const tt", ttv[1], 4'b1111);
    check("const sel", sf[1], 3'b111);
    check("const unknown", unk[1], 1);
    check("const done count", ndone, 1);

    // Test 4: reset in the middle of an XOR run.
    mode = 4'd4;
    @(negedge clk);
    start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("xor pre-rst probes", {pa[1], pb[1]}, 2'b10);
    rst = 1'b1;
    #1;
    check("rst busy", bsy[1], 0);
    check("rst probes", {pa[1], pb[1]}, 0);
    check("rst sel cleared", sf[1], 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (dn[1]) ndone++;
    end
    check("rst no done", ndone, 0);
    run_all(4'd4);
    check("xor restart sel", sf[1], 3'b100);

    // Test 5: start re-pulsed during a run is ignored.
    mode = 4'd3;
    @(negedge clk);
    start = 1'b1;
    k = cyc + 1;
    ndone = 0;
    d1 = -1;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      start = (j == 1 || j == 4) ? 1'b1 : 1'b0;
      if (dn[1]) begin
        ndone++;
        if (d1 < 0) d1 = cyc + 1 - k;
      end
    end
    check("repulse done count", ndone, 1);
    check("repulse done cycle", d1, 9);
    check("repulse sel", sf[1], 3'b011);

    // start held high: back-to-back runs, one idle cycle between.
    mode = 4'd1;
    @(negedge clk);
    start = 1'b1;
    k = cyc + 1;
    d1 = -1;
    d2 = -1;
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (dn[1]) begin
        ndone++;
        if (d1 < 0) d1 = cyc;
        else if (d2 < 0) d2 = cyc;
      end
    end
    start = 1'b0;
    check("held first done", d1 + 1 - k, 9);
    check("held spacing", d2 - d1, 10);
    check("held sel", sf[1], 3'b001);
    repeat (25) @(negedge clk);

`ifdef GFI_CHECK_EN
    // Test 6: built-in pass/fail compare, all SETTLE values.
    exp_sel = 3'b101;
    run_all(4'd5);
    for (int i = 0; i < 3; i++) check($sformatf("pass xnor %0d", i), pas[i], 1);
    exp_sel = 3'b100;
    run_all(4'd5);
    for (int i = 0; i < 3; i++) check($sformatf("pass xnor bad %0d", i), pas[i], 0);
    exp_sel = 3'b111;
    run_all(4'd6);
    for (int i = 0; i < 3; i++) check($sformatf("pass nand alias %0d", i), pas[i], 1);
    for (int i = 0; i < 3; i++) check($sformatf("chk latency %0d", i), dcyc[i], lat_exp[i]);
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
